draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer.sv | 169 ++++++++++++++++
 tb/tb_draw_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: drives the VGA pixel stream. After reset or a clear request it
// hands the screen to the init-screen stage and forwards that stage's pixels.
// Otherwise it paints one CELL_PX x CELL_PX grid cell per accepted request.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   clear_req                     request a full-screen redraw through the init stage
//   cell_valid/cell_ready         cell paint handshake (cell_col, cell_row, cell_colour)
//   init_start                    one-cycle start pulse to the init-screen stage
//   init_waitrequest              init-screen stage busy
//   init_plot/x/y/colour          pixel stream from the init-screen stage
//   vga_plot/x/y/colour           pixel stream to the VGA adapter
//   busy                          high whenever the sequencer is not idle
module draw_sequencer #(
    parameter int unsigned ORIGIN_X = 32,
    parameter int unsigned ORIGIN_Y = 12,
    parameter int unsigned CELL_PX  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_req,
    input  logic       cell_valid,
    output logic       cell_ready,
    input  logic [3:0] cell_col,
    input  logic [3:0] cell_row,
    input  logic [2:0] cell_colour,
    output logic       init_start,
    input  logic       init_waitrequest,
    input  logic       init_plot,
    input  logic [7:0] init_x,
    input  logic [6:0] init_y,
    input  logic [2:0] init_colour,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       busy
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;
    localparam int unsigned GW = 4;
    localparam int unsigned DW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(CELL_PX - 1);

    typedef enum logic [1:0] {
        ST_INIT_START = 2'd0,
        ST_INIT_BUSY  = 2'd1,
        ST_IDLE       = 2'd2,
        ST_PAINT      = 2'd3
    } state_t;

    state_t        state, state_d;
    logic          init_seen, init_seen_d;
    logic [DW-1:0] dx, dx_d;
    logic [DW-1:0] dy, dy_d;
    logic [GW-1:0] col_q, col_d;
    logic [GW-1:0] row_q, row_d;
    logic [CW-1:0] colour_q, colour_d;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    // Current paint pixel; modulo-256 / modulo-128 arithmetic, max (127,107) for a 16x16 grid
    assign pix_x = XW'(ORIGIN_X) + XW'(CELL_PX) * XW'(col_q) + XW'(dx);
    assign pix_y = YW'(ORIGIN_Y) + YW'(CELL_PX) * YW'(row_q) + YW'(dy);

    // State and captured-cell registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT_START;
            init_seen <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            col_q     <= '0;
            row_q     <= '0;
            colour_q  <= '0;
        end else begin
            state     <= state_d;
            init_seen <= init_seen_d;
            dx        <= dx_d;
            dy        <= dy_d;
            col_q     <= col_d;
            row_q     <= row_d;
            colour_q  <= colour_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state;
        init_seen_d = 1'b0;
        dx_d        = dx;
        dy_d        = dy;
        col_d       = col_q;
        row_d       = row_q;
        colour_d    = colour_q;
        init_start  = 1'b0;
        cell_ready  = 1'b0;
        vga_plot    = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;

        case (state)
            ST_INIT_START: begin
                init_start = 1'b1;
                state_d    = ST_INIT_BUSY;
            end
            ST_INIT_BUSY: begin
                vga_plot    = init_plot;
                vga_x       = init_x;
                vga_y       = init_y;
                vga_colour  = init_colour;
                // init_seen is clear on the entry cycle, so a stale low waitrequest cannot exit
                init_seen_d = 1'b1;
                if (init_seen && !init_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_INIT_START;
                end else begin
                    cell_ready = 1'b1;
                    if (cell_valid) begin
                        col_d    = cell_col;
                        row_d    = cell_row;
                        colour_d = cell_colour;
                        dx_d     = '0;
                        dy_d     = '0;
                        state_d  = ST_PAINT;
                    end
                end
            end
            ST_PAINT: begin
                vga_plot   = 1'b1;
                vga_x      = pix_x;
                vga_y      = pix_y;
                vga_colour = colour_q;
                // dx-fastest raster scan of the cell
                if (dx == D_LAST) begin
                    dx_d = '0;
                    if (dy == D_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        dy_d = dy + DW'(1);
                    end
                end else begin
                    dx_d = dx + DW'(1);
                end
            end
            default: state_d = ST_INIT_START;
        endcase

        // Outputs are quiet while reset is held, independent of the pre-reset state
        if (!rst_n) begin
            init_start = 1'b0;
            cell_ready = 1'b0;
            vga_plot   = 1'b0;
            vga_x      = '0;
            vga_y      = '0;
            vga_colour = '0;
        end
    end

    assign busy = !rst_n || (state != ST_IDLE);

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: expected pixels are queued as stimulus is
// issued (cells and the init-screen model); a negedge monitor pops and compares.
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_req;
    logic       cell_valid;
    logic       cell_ready;
    logic [3:0] cell_col;
    logic [3:0] cell_row;
    logic [2:0] cell_colour;
    logic       init_start;
    logic       init_waitrequest;
    logic       init_plot;
    logic [7:0] init_x;
    logic [6:0] init_y;
    logic [2:0] init_colour;
    logic       vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       busy;

    always #5 clk = ~clk;

    draw_sequencer #(
        .ORIGIN_X(32),
        .ORIGIN_Y(12),
        .CELL_PX (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_req       (clear_req),
        .cell_valid      (cell_valid),
        .cell_ready      (cell_ready),
        .cell_col        (cell_col),
        .cell_row        (cell_row),
        .cell_colour     (cell_colour),
        .init_start      (init_start),
        .init_waitrequest(init_waitrequest),
        .init_plot       (init_plot),
        .init_x          (init_x),
        .init_y          (init_y),
        .init_colour     (init_colour),
        .vga_plot        (vga_plot),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .busy            (busy)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   start_pulses = 0;
    logic start_seen = 1'b0;
    logic prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every plotted pixel, checks quiet outputs in IDLE
    always @(negedge clk) begin
        pix_t p;
        start_seen = init_start;
        if (init_start) begin
            start_pulses++;
            check("init_start_one_cycle", 32'(prev_start), 0);
        end
        prev_start = init_start;
        if (vga_plot) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%0d) expected no pixel at %0t",
                         vga_x, vga_y, vga_colour, $time);
            end else begin
                p = exp_q.pop_front();
                check("pix_x", 32'(vga_x), 32'(p.x));
                check("pix_y", 32'(vga_y), 32'(p.y));
                check("pix_colour", 32'(vga_colour), 32'(p.c));
            end
        end else if (!busy) begin
            check("idle_vga_zero", {14'd0, vga_x, vga_y, vga_colour}, 0);
        end
    end

    // Init-screen model: after an init_start pulse, optional dead cycles with
    // waitrequest low, then init_len pixels with waitrequest high.
    int init_len = 19200;
    int init_lat = 0;
    int idx = 0;
    int lat_cnt = 0;
    logic active = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            active           = 1'b0;
            init_waitrequest = 1'b0;
            init_plot        = 1'b0;
        end else begin
            if (start_seen) begin
                active  = 1'b1;
                idx     = 0;
                lat_cnt = init_lat;
            end
            if (active) begin
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    init_waitrequest = 1'b0;
                    init_plot        = 1'b0;
                end else if (idx < init_len) begin
                    init_waitrequest = 1'b1;
                    init_plot        = 1'b1;
                    init_x           = 8'(idx % 160);
                    init_y           = 7'(idx / 160);
                    init_colour      = 3'(idx);
                    exp_q.push_back({init_x, init_y, init_colour});
                    idx++;
                end else begin
                    init_waitrequest = 1'b0;
                    init_plot        = 1'b0;
                    active           = 1'b0;
                end
            end
        end
    end

    // Counts cycles until cell_ready; first awaited negedge is cycle n0
    task automatic wait_ready(input int n0, input int exp_n, input string name);
        int n;
        for (n = n0; n < exp_n + 20; n++) begin
            @(negedge clk);
            if (cell_ready) break;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    // Queues the 36 expected pixels from hand-computed origin (x0,y0), then handshakes
    task automatic send_cell(input logic [3:0] col, input logic [3:0] row, input logic [2:0] colour,
                             input int x0, input int y0, input logic hold, input string name);
        int n;
        cell_col    = col;
        cell_row    = row;
        cell_colour = colour;
        cell_valid  = 1'b1;
        for (int dy = 0; dy < 6; dy++)
            for (int dx = 0; dx < 6; dx++)
                exp_q.push_back({8'(x0 + dx), 7'(y0 + dy), colour});
        #1;
        for (n = 0; n < 50; n++) begin
            if (cell_ready) break;
            @(negedge clk);
            #1;
        end
        check(name, 32'(cell_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) cell_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        clear_req        = 1'b0;
        cell_valid       = 1'b0;
        cell_col         = '0;
        cell_row         = '0;
        cell_colour      = '0;
        init_waitrequest = 1'b0;
        init_plot        = 1'b0;
        init_x           = '0;
        init_y           = '0;
        init_colour      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_start", 32'(init_start), 0);
        check("rst_cell_ready", 32'(cell_ready), 0);
        check("rst_vga_plot", 32'(vga_plot), 0);
        check("rst_vga_xyc", {14'd0, vga_x, vga_y, vga_colour}, 0);
        check("rst_busy", 32'(busy), 1);

        // Release: one init_start pulse, 19200 mirrored pixels, ready at cycle 19202
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_init_start", 32'(init_start), 1);
        check("first_busy", 32'(busy), 1);
        wait_ready(1, 19202, "init_ready_latency");
        check("init_pixels_done", 32'(exp_q.size()), 0);
        check("init_pulses_1", 32'(start_pulses), 1);
        check("idle_busy", 32'(busy), 0);

        // Cell (0,0): x 32..37, y 12..17; ready on cycle 37 after acceptance
        send_cell(4'd0, 4'd0, 3'b010, 32, 12, 1'b0, "accept_00");
        wait_ready(1, 37, "paint_ready_latency");
        drain("drain_00");

        // Cell (15,15): last pixel (127,107)
        send_cell(4'd15, 4'd15, 3'b111, 122, 102, 1'b0, "accept_ff");
        wait_ready(1, 37, "paint_ready_ff");
        drain("drain_ff");

        // Valid held through PAINT with new fields: second cell taken on cycle 37
        send_cell(4'd1, 4'd2, 3'b001, 38, 24, 1'b1, "accept_a");
        cell_col    = 4'd10;
        cell_row    = 4'd7;
        cell_colour = 3'b110;
        for (int dy = 0; dy < 6; dy++)
            for (int dx = 0; dx < 6; dx++)
                exp_q.push_back({8'(92 + dx), 7'(54 + dy), 3'b110});
        wait_ready(1, 37, "second_accept_cycle");
        @(posedge clk);
        #1 cell_valid = 1'b0;
        @(negedge clk);
        check("b_painting", 32'(vga_plot), 1);
        drain("drain_ab");

        // Clear wins over a same-cycle cell request; init exit ignores low waitrequest on entry
        init_len  = 40;
        init_lat  = 1;
        clear_req = 1'b1;
        cell_valid = 1'b1;
        cell_col   = 4'd2;
        cell_row   = 4'd2;
        cell_colour = 3'b011;
        #1;
        check("clear_ready_low", 32'(cell_ready), 0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        cell_valid = 1'b0;
        @(negedge clk);
        check("clear_init_start", 32'(init_start), 1);
        wait_ready(1, 43, "clear_init_ready");
        drain("drain_clear");
        check("init_pulses_2", 32'(start_pulses), 2);

        // Reset at pixel 10 of a paint aborts it; no further cell pixels after restart
        init_len = 30;
        init_lat = 0;
        send_cell(4'd5, 4'd3, 3'b101, 62, 30, 1'b0, "accept_53");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_plot_now", 32'(vga_plot), 0);
        @(posedge clk);
        @(negedge clk);
        check("abort_plot_next", 32'(vga_plot), 0);
        check("abort_busy", 32'(busy), 1);
        check("abort_init_start", 32'(init_start), 0);
        check("abort_ready", 32'(cell_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("restart_init_start", 32'(init_start), 1);
        wait_ready(1, 32, "restart_init_ready");
        repeat (20) @(negedge clk);
        check("restart_queue_empty", 32'(exp_q.size()), 0);
        check("init_pulses_3", 32'(start_pulses), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
